mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_STATES, default 2, number of idle cycles (0-15) between request acceptance and response.
REQ-002 Parameter DEPTH, default 512, number of 32-bit words in the memory array.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 Port read  input  1  level request to read the word at address into Mdatain.
REQ-006 Port write  input  1  level request to write data_in to the word at address.
REQ-007 Port address  input  9  word address (MAR value); sampled only when a request is accepted.
REQ-008 Port data_in  input  32  write data (MDR value); sampled only when a request is accepted.
REQ-009 Port Mdatain  output  32  read data toward the MDR; holds the last read value.
REQ-010 Port done  output  1  one-cycle pulse marking completion of an accepted access.
REQ-011 Port busy  output  1  high in every state except IDLE.
REQ-012 Port err  output  1  sticky flag: a request had read and write high together.

Function
REQ-013 The FSM SHALL have four states: IDLE, WAIT, RESP and HOLD.
REQ-014 In IDLE, exactly one of read/write high at a rising edge SHALL accept the request.
- address, data_in and the request type are latched on that edge.
- The next state is WAIT, or RESP when WAIT_STATES=0.
REQ-015 In IDLE, read and write both high SHALL set err, perform no memory access, and move to HOLD without a done pulse.
REQ-016 A down-counter loaded with WAIT_STATES-1 on entry to WAIT SHALL decrement once per cycle, and the FSM SHALL move to RESP on the edge where the counter is 0.
REQ-017 On the edge entering RESP, a write SHALL commit the latched data_in to mem[latched address].
REQ-018 On the edge entering RESP, a read SHALL load Mdatain with mem[latched address].
REQ-019 done SHALL be high for exactly the single cycle spent in RESP.
- Read latency is WAIT_STATES+1 cycles from the acceptance edge to done high.
REQ-020 RESP SHALL always go to HOLD on the next edge.
REQ-021 HOLD SHALL stay until read and write are both low, then return to IDLE, so that a level held high is serviced only once.
REQ-022 Changes on read, write, address or data_in while in WAIT, RESP or HOLD SHALL be ignored.
REQ-023 A read of a word written by the immediately preceding access SHALL return the new data.
REQ-024 Mdatain SHALL change only on read completion; write accesses and error requests leave it unchanged.
REQ-025 err SHALL clear only on reset.

Reset
REQ-026 reset_n low SHALL immediately force the following, regardless of clk:
- state=IDLE, counter=0
- Mdatain=32'h00000000
- done=0, busy=0, err=0
REQ-027 Memory array contents SHALL NOT be altered by reset.
REQ-028 Reset asserted in WAIT SHALL abort the access: no write is committed and Mdatain is unchanged apart from the reset clear.
REQ-029 After reset_n rises, the first rising edge SHALL evaluate requests as in IDLE.

Verification
REQ-030 Write then read: write=1, address=0, data_in=32'h4A920000, held 1 cycle; then read=1, address=0.
- The write's done pulse arrives 3 cycles after acceptance.
- The read's done pulse arrives 3 cycles after acceptance, with Mdatain=32'h4A920000.
REQ-031 Back-to-back operand loads: write 0x22, 0x24, 0x26 to addresses 2, 4, 5, then read each address.
- Mdatain returns 0x22, 0x24, 0x26 in order.
- Exactly one done pulse occurs per access.
REQ-032 Held level: read held high for 10 cycles -> exactly one done pulse; busy stays high in HOLD until read falls, then returns to IDLE.
REQ-033 Conflict: read=1 and write=1 together -> err=1, no done pulse, memory and Mdatain unchanged, err remains 1 after both requests fall.
REQ-034 Reset mid-write: reset_n pulsed low in WAIT during a write of 0xDEADBEEF to address 7 -> a later read of address 7 returns its prior value; all outputs are 0 during reset.
REQ-035 WAIT_STATES=0 build: read accepted at edge N -> done high in cycle N+1 with valid Mdatain.

Source files
------------

// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if
// Request/response bundle between a processor-side requester (master) and
// the mem_responder memory model (slave).
//   read     : level request to read mem[address] into Mdatain
//   write    : level request to write data_in to mem[address]
//   address  : 9-bit word address (MAR value)
//   data_in  : 32-bit write data (MDR value)
//   Mdatain  : 32-bit read data toward the MDR, holds the last read value
//   done     : one-cycle completion pulse of an accepted access
//   busy     : responder is not idle
//   err      : sticky flag, read and write were requested together
// ---------------------------------------------------------------------------
interface mem_responder_if;
  logic        read;
  logic        write;
  logic [8:0]  address;
  logic [31:0] data_in;
  logic [31:0] Mdatain;
  logic        done;
  logic        busy;
  logic        err;

  modport master (
    output read, write, address, data_in,
    input  Mdatain, done, busy, err
  );

  modport slave (
    input  read, write, address, data_in,
    output Mdatain, done, busy, err
  );
endinterface : mem_responder_if

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Word-addressed 32-bit memory with a fixed number of wait states, answering
// level-sensitive read/write requests with a single done pulse.
//   clk      : single clock, all state changes on its rising edge
//   reset_n  : asynchronous active-low reset (memory contents untouched)
//   bus      : mem_responder_if.slave (read, write, address, data_in in;
//              Mdatain, done, busy, err out)
// Parameters:
//   WAIT_STATES : idle cycles (0-15) between acceptance and response
//   DEPTH       : number of 32-bit words
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int WAIT_STATES = 2,
  parameter int DEPTH       = 512
) (
  input  logic           clk,
  input  logic           reset_n,
  mem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  // Counter start value; only used when WAIT_STATES is nonzero.
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [8:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        is_wr_q, is_wr_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic [31:0] mdatain_q, mdatain_d;
  logic        mem_we_s;
  logic        mem_re_s;
  logic [31:0] rd_word_s;

  logic [31:0] mem_q [DEPTH];

  // Next-state, request latching and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    is_wr_d = is_wr_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.read && bus.write) begin
          // Conflicting request: flag it and park in HOLD without access.
          err_d   = 1'b1;
          state_d = S_HOLD;
        end else if (bus.read || bus.write) begin
          addr_d  = bus.address;
          data_d  = bus.data_in;
          is_wr_d = bus.write;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        // Wait for the level request to drop so it is serviced only once.
        if (!bus.read && !bus.write) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The access happens on the edge that enters RESP. Using the *_d copies
    // covers the zero-wait case where latching and entry share one edge.
    // Gating with reset_n keeps a held reset from committing a write.
    mem_we_s  = reset_n && (state_d == S_RESP) && is_wr_d;
    mem_re_s  = (state_d == S_RESP) && !is_wr_d;
    rd_word_s = mem_q[addr_d];

    if (mem_re_s) begin
      mdatain_d = rd_word_s;
    end else begin
      mdatain_d = mdatain_q;
    end

    done_d = (state_d == S_RESP);
    busy_d = (state_d != S_IDLE);
  end

  // Control state, latched request and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 9'd0;
      data_q    <= 32'd0;
      is_wr_q   <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      mdatain_q <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      is_wr_q   <= is_wr_d;
      err_q     <= err_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      mdatain_q <= mdatain_d;
    end
  end

  // Memory array: no reset so contents survive reset_n.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[addr_d] <= data_d;
    end else begin
      mem_q[addr_d] <= mem_q[addr_d];
    end
  end

  assign bus.Mdatain = mdatain_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.err     = err_q;

endmodule : mem_responder

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
// Directed bench for mem_responder. Two instances share one stimulus stream:
// dut0 with WAIT_STATES=2 and dut1 with WAIT_STATES=0.
// ---------------------------------------------------------------------------
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tb_read;
  logic        tb_write;
  logic [8:0]  tb_addr;
  logic [31:0] tb_data;

  int total = 0;
  int bad   = 0;

  int          first0, first1, ndone0, ndone1;
  logic [31:0] rdata0, rdata1;
  logic        busy_hist [1:12];

  mem_responder_if bus0 ();
  mem_responder_if bus1 ();

  assign bus0.read    = tb_read;
  assign bus0.write   = tb_write;
  assign bus0.address = tb_addr;
  assign bus0.data_in = tb_data;
  assign bus1.read    = tb_read;
  assign bus1.write   = tb_write;
  assign bus1.address = tb_addr;
  assign bus1.data_in = tb_data;

  mem_responder #(.WAIT_STATES(2), .DEPTH(512)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );

  mem_responder #(.WAIT_STATES(0), .DEPTH(512)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  always #5 clk = ~clk;

  // One access: request driven at a negedge, accepted at the next posedge,
  // then 12 cycles observed at negedges. Inputs drop at cycle 'hold'; at
  // cycle 1 address/data are scrambled to show they are ignored after accept.
  task automatic run_access(input logic rd, input logic wr, input logic [8:0] a,
                            input logic [31:0] d, input int hold);
    @(negedge clk);
    tb_read  = rd;
    tb_write = wr;
    tb_addr  = a;
    tb_data  = d;
    @(posedge clk);
    first0 = 0; first1 = 0; ndone0 = 0; ndone1 = 0;
    rdata0 = 32'hxxxx_xxxx; rdata1 = 32'hxxxx_xxxx;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      busy_hist[k] = bus0.busy;
      if (bus0.done) begin
        ndone0++;
        if (first0 == 0) first0 = k;
        rdata0 = bus0.Mdatain;
      end
      if (bus1.done) begin
        ndone1++;
        if (first1 == 0) first1 = k;
        rdata1 = bus1.Mdatain;
      end
      if (k == 1) begin
        tb_addr = ~a;
        tb_data = ~d;
      end
      if (k == hold) begin
        tb_read  = 1'b0;
        tb_write = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; tb_read = 1'b0; tb_write = 1'b0; tb_addr = 9'd0; tb_data = 32'd0;
    #12;
    total++; if (bus0.Mdatain !== 32'h0) begin bad++; $display("FAIL reset_mdatain0 got=%h exp=%h", bus0.Mdatain, 32'h0); end
    total++; if (bus0.done !== 1'b0) begin bad++; $display("FAIL reset_done0 got=%b exp=0", bus0.done); end
    total++; if (bus0.busy !== 1'b0) begin bad++; $display("FAIL reset_busy0 got=%b exp=0", bus0.busy); end
    total++; if (bus0.err !== 1'b0) begin bad++; $display("FAIL reset_err0 got=%b exp=0", bus0.err); end
    total++; if (bus1.Mdatain !== 32'h0) begin bad++; $display("FAIL reset_mdatain1 got=%h exp=%h", bus1.Mdatain, 32'h0); end
    total++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL reset_busy1 got=%b exp=0", bus1.busy); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_write_read;
    run_access(1'b0, 1'b1, 9'd0, 32'h4A92_0000, 1);
    total++; if (first0 !== 3) begin bad++; $display("FAIL wr_latency got=%0d exp=3", first0); end
    total++; if (ndone0 !== 1) begin bad++; $display("FAIL wr_done_count got=%0d exp=1", ndone0); end
    total++; if (bus0.Mdatain !== 32'h0) begin bad++; $display("FAIL wr_mdatain_kept got=%h exp=%h", bus0.Mdatain, 32'h0); end
    run_access(1'b1, 1'b0, 9'd0, 32'd0, 1);
    total++; if (first0 !== 3) begin bad++; $display("FAIL rd_latency got=%0d exp=3", first0); end
    total++; if (rdata0 !== 32'h4A92_0000) begin bad++; $display("FAIL rd_data got=%h exp=%h", rdata0, 32'h4A92_0000); end
  endtask

  task automatic test_back_to_back;
    logic [8:0]  addrs [3];
    logic [31:0] vals  [3];
    addrs[0] = 9'd2; addrs[1] = 9'd4; addrs[2] = 9'd5;
    vals[0] = 32'h22; vals[1] = 32'h24; vals[2] = 32'h26;
    for (int i = 0; i < 3; i++) begin
      run_access(1'b0, 1'b1, addrs[i], vals[i], 1);
      total++; if (ndone0 !== 1) begin bad++; $display("FAIL b2b_wr_done%0d got=%0d exp=1", i, ndone0); end
    end
    for (int i = 0; i < 3; i++) begin
      run_access(1'b1, 1'b0, addrs[i], 32'd0, 1);
      total++; if (rdata0 !== vals[i]) begin bad++; $display("FAIL b2b_rd%0d got=%h exp=%h", i, rdata0, vals[i]); end
      total++; if (ndone0 !== 1) begin bad++; $display("FAIL b2b_rd_done%0d got=%0d exp=1", i, ndone0); end
    end
  endtask

  task automatic test_held_level;
    run_access(1'b1, 1'b0, 9'd4, 32'd0, 10);
    total++; if (ndone0 !== 1) begin bad++; $display("FAIL held_done_count got=%0d exp=1", ndone0); end
    total++; if (rdata0 !== 32'h24) begin bad++; $display("FAIL held_data got=%h exp=%h", rdata0, 32'h24); end
    total++; if (busy_hist[10] !== 1'b1) begin bad++; $display("FAIL held_busy_in_hold got=%b exp=1", busy_hist[10]); end
    total++; if (busy_hist[11] !== 1'b0) begin bad++; $display("FAIL held_busy_after got=%b exp=0", busy_hist[11]); end
    total++; if (ndone1 !== 1) begin bad++; $display("FAIL held_done_count_ws0 got=%0d exp=1", ndone1); end
  endtask

  task automatic test_conflict;
    run_access(1'b1, 1'b1, 9'd2, 32'hFFFF_FFFF, 1);
    total++; if (ndone0 !== 0) begin bad++; $display("FAIL conflict_done got=%0d exp=0", ndone0); end
    total++; if (bus0.err !== 1'b1) begin bad++; $display("FAIL conflict_err got=%b exp=1", bus0.err); end
    total++; if (busy_hist[1] !== 1'b1) begin bad++; $display("FAIL conflict_busy got=%b exp=1", busy_hist[1]); end
    total++; if (bus0.Mdatain !== 32'h24) begin bad++; $display("FAIL conflict_mdatain got=%h exp=%h", bus0.Mdatain, 32'h24); end
    run_access(1'b1, 1'b0, 9'd2, 32'd0, 1);
    total++; if (rdata0 !== 32'h22) begin bad++; $display("FAIL conflict_mem got=%h exp=%h", rdata0, 32'h22); end
    total++; if (bus0.err !== 1'b1) begin bad++; $display("FAIL conflict_err_sticky got=%b exp=1", bus0.err); end
  endtask

  task automatic test_reset_mid_write;
    run_access(1'b0, 1'b1, 9'd7, 32'h1111_1111, 1);
    @(negedge clk);
    tb_write = 1'b1; tb_addr = 9'd7; tb_data = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    total++; if (bus0.busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_wait got=%b exp=1", bus0.busy); end
    reset_n = 1'b0; tb_write = 1'b0;
    #1;
    total++; if (bus0.Mdatain !== 32'h0) begin bad++; $display("FAIL midrst_mdatain got=%h exp=%h", bus0.Mdatain, 32'h0); end
    total++; if (bus0.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", bus0.busy); end
    total++; if (bus0.err !== 1'b0) begin bad++; $display("FAIL midrst_err got=%b exp=0", bus0.err); end
    total++; if (bus0.done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", bus0.done); end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    run_access(1'b1, 1'b0, 9'd7, 32'd0, 1);
    total++; if (rdata0 !== 32'h1111_1111) begin bad++; $display("FAIL midrst_prior got=%h exp=%h", rdata0, 32'h1111_1111); end
    total++; if (first0 !== 3) begin bad++; $display("FAIL midrst_latency got=%0d exp=3", first0); end
  endtask

  task automatic test_zero_wait;
    run_access(1'b0, 1'b1, 9'd3, 32'hA5A5_0003, 1);
    total++; if (first1 !== 1) begin bad++; $display("FAIL ws0_wr_latency got=%0d exp=1", first1); end
    run_access(1'b1, 1'b0, 9'd3, 32'd0, 1);
    total++; if (first1 !== 1) begin bad++; $display("FAIL ws0_rd_latency got=%0d exp=1", first1); end
    total++; if (rdata1 !== 32'hA5A5_0003) begin bad++; $display("FAIL ws0_rd_data got=%h exp=%h", rdata1, 32'hA5A5_0003); end
    total++; if (ndone1 !== 1) begin bad++; $display("FAIL ws0_done_count got=%0d exp=1", ndone1); end
    total++; if (rdata0 !== 32'hA5A5_0003) begin bad++; $display("FAIL ws2_rd_data got=%h exp=%h", rdata0, 32'hA5A5_0003); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_held_level();
    test_conflict();
    test_reset_mid_write();
    test_zero_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule : tb_mem_responder
